// File: rtl/request_dispatcher.sv
// Round-robin request dispatcher: spreads client requests over NUM_SERVERS servers and
// returns their results to the client in acceptance order. Define REQUEST_DISPATCHER_BYPASS_EN for zero-latency result bypass.
module request_dispatcher #(
    parameter int SERV_DATA_WIDTH = 72,
    parameter int RSLT_DATA_WIDTH = SERV_DATA_WIDTH,
    parameter int SUPP_DATA_WIDTH = 19,
    parameter int NUM_SERVERS     = 4,
    parameter int FIFO_DEPTH_BITS = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [SUPP_DATA_WIDTH-1:0]             client_supp_data,
    input  logic [SERV_DATA_WIDTH-1:0]             client_serv_data,
    input  logic                                   client_req,
    output logic                                   client_ack,
    output logic                                   client_vld,
    output logic [RSLT_DATA_WIDTH-1:0]             client_rslt_data,
    output logic [SUPP_DATA_WIDTH*NUM_SERVERS-1:0] server_supp_data,
    output logic [SERV_DATA_WIDTH*NUM_SERVERS-1:0] server_serv_data,
    output logic [NUM_SERVERS-1:0]                 server_req,
    input  logic [NUM_SERVERS-1:0]                 server_ack,
    input  logic [NUM_SERVERS-1:0]                 server_vld,
    input  logic [RSLT_DATA_WIDTH*NUM_SERVERS-1:0] server_rslt_data,
    output logic                                   overflow_err
);
    localparam int SEL_W = $clog2(NUM_SERVERS);
    localparam int DEPTH = 2 ** FIFO_DEPTH_BITS;
    localparam int CNT_W = FIFO_DEPTH_BITS + 1;

    typedef logic [SEL_W-1:0]           sel_t;
    typedef logic [RSLT_DATA_WIDTH-1:0] rslt_t;
    typedef logic [FIFO_DEPTH_BITS-1:0] ptr_t;

    sel_t                   sel_q, sel_d;
    sel_t                   order_q [DEPTH];
    sel_t                   order_d [DEPTH];
    ptr_t                   wr_ptr_q, wr_ptr_d;
    ptr_t                   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [NUM_SERVERS-1:0] buf_vld_q, buf_vld_d;
    rslt_t                  buf_data_q [NUM_SERVERS];
    rslt_t                  buf_data_d [NUM_SERVERS];
    logic                   overflow_q, overflow_d;

    rslt_t                  srv_rslt [NUM_SERVERS];
    logic                   fifo_full, fifo_empty;
    logic                   push, pop, bypass;
    sel_t                   head;
    logic [NUM_SERVERS-1:0] drain;

    // Every server sees the client request data; only server_req selects who takes it.
    assign server_supp_data = {NUM_SERVERS{client_supp_data}};
    assign server_serv_data = {NUM_SERVERS{client_serv_data}};

    // Server 0 occupies the most-significant slice of the packed result bus.
    for (genvar g = 0; g < NUM_SERVERS; g++) begin : g_unpack
        assign srv_rslt[g] = server_rslt_data[(NUM_SERVERS-1-g)*RSLT_DATA_WIDTH +: RSLT_DATA_WIDTH];
    end

    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign head       = order_q[rd_ptr_q];

    always_comb begin
        for (int i = 0; i < NUM_SERVERS; i++) begin
            server_req[i] = reset && client_req && !fifo_full && (sel_q == sel_t'(i));
        end
    end

    assign client_ack   = server_req[sel_q] & server_ack[sel_q];
    assign push         = client_ack;
    assign overflow_err = overflow_q;

    always_comb begin
        bypass = 1'b0;
`ifdef REQUEST_DISPATCHER_BYPASS_EN
        bypass = !fifo_empty && !buf_vld_q[head] && server_vld[head];
`endif
        drain       = '0;
        drain[head] = !fifo_empty && buf_vld_q[head];
        pop         = (|drain) || bypass;
        client_vld  = pop;
        client_rslt_data = bypass ? srv_rslt[head] : buf_data_q[head];
    end

    always_comb begin
        // NOTE: each _d starts from its _q so every path assigns it and no latch is inferred.
        sel_d      = sel_q;
        order_d    = order_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        buf_vld_d  = buf_vld_q;
        buf_data_d = buf_data_q;
        overflow_d = overflow_q;

        if (push) begin
            order_d[wr_ptr_q] = sel_q;
            wr_ptr_d          = wr_ptr_q + ptr_t'(1);
            sel_d             = sel_q + sel_t'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        // A bypassed result goes straight to the client and never touches the buffer.
        for (int i = 0; i < NUM_SERVERS; i++) begin
            if (drain[i]) begin
                buf_vld_d[i] = 1'b0;
            end
            if (server_vld[i] && !(bypass && head == sel_t'(i))) begin
                if (buf_vld_q[i] && !drain[i]) begin
                    overflow_d = 1'b1;
                end
                buf_vld_d[i]  = 1'b1;
                buf_data_d[i] = srv_rslt[i];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            buf_vld_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            sel_q      <= sel_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            buf_vld_q  <= buf_vld_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: storage arrays carry no reset; the FIFO count and buffer valid bits qualify every read.
    always_ff @(posedge clk) begin
        order_q    <= order_d;
        buf_data_q <= buf_data_d;
    end

endmodule
